byte_striping_ctrl: RTL

//   Lane scheduler for the 4-lane byte-striping datapath.

---
 rtl/byte_striping_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/byte_striping_ctrl.sv
// byte_striping_ctrl: round-robin byte scheduler for a 1/2/4-lane striping datapath with end-of-frame padding
module byte_striping_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'hF7
) (
  input  logic                  stripingCLK,
  input  logic                  stripingRST_L,
  input  logic [DATA_WIDTH-1:0] byteIN,
  input  logic                  byteVLD,
  output logic                  byteRDY,
  input  logic [1:0]            laneCfg,
  output logic [DATA_WIDTH-1:0] laneData,
  output logic [3:0]            laneWE,
  output logic [1:0]            laneSel,
  output logic                  groupDone,
  output logic                  padActive
);
  typedef enum logic [1:0] {IDLE, STRIPE, PAD} state_t;
  state_t                state_q;
  logic [1:0]            ptr_q;
  logic [1:0]            cfg_q;
  logic [DATA_WIDTH-1:0] lane_data_q;
  logic [3:0]            lane_we_q;
  logic [1:0]            lane_sel_q;
  logic                  group_done_q;
  logic                  pad_active_q;
  logic [1:0]            last_d;
  logic [1:0]            last_new_d;
  logic [1:0]            ptr_inc_d;
  // Index of the last active lane for the latched and the incoming configuration, and the wrapped next pointer
  always_comb begin
    last_d     = cfg_q == 2'b00 ? 2'd0 : cfg_q == 2'b01 ? 2'd1 : 2'd3;
    last_new_d = laneCfg == 2'b00 ? 2'd0 : laneCfg == 2'b01 ? 2'd1 : 2'd3;
    ptr_inc_d  = ptr_q == last_d ? 2'd0 : ptr_q + 2'd1;
  end
  assign byteRDY   = state_q != PAD;
  assign laneData  = lane_data_q;
  assign laneWE    = lane_we_q;
  assign laneSel   = lane_sel_q;
  assign groupDone = group_done_q;
  assign padActive = pad_active_q;
  // Frame FSM; write strobes are single-cycle, so they default low every cycle and are raised only on a write
  always_ff @(posedge stripingCLK or negedge stripingRST_L) begin
    if (!stripingRST_L) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      cfg_q        <= 2'b10;
      lane_data_q  <= '0;
      lane_we_q    <= 4'b0000;
      lane_sel_q   <= 2'd0;
      group_done_q <= 1'b0;
      pad_active_q <= 1'b0;
    end else begin
      lane_we_q    <= 4'b0000;
      lane_sel_q   <= 2'd0;
      group_done_q <= 1'b0;
      pad_active_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (byteVLD) begin
            cfg_q        <= laneCfg;
            lane_data_q  <= byteIN;
            lane_we_q    <= 4'b0001;
            group_done_q <= last_new_d == 2'd0;
            ptr_q        <= last_new_d == 2'd0 ? 2'd0 : 2'd1;
            state_q      <= last_new_d == 2'd0 ? IDLE : STRIPE;
          end
        end
        STRIPE: begin
          if (byteVLD) begin
            lane_data_q  <= byteIN;
            lane_we_q    <= 4'b0001 << ptr_q;
            lane_sel_q   <= ptr_q;
            group_done_q <= ptr_q == last_d;
            ptr_q        <= ptr_inc_d;
          end else if (ptr_q == 2'd0) begin
            state_q <= IDLE;
          end else begin
            lane_data_q  <= PAD_BYTE;
            lane_we_q    <= 4'b0001 << ptr_q;
            lane_sel_q   <= ptr_q;
            pad_active_q <= 1'b1;
            group_done_q <= ptr_q == last_d;
            ptr_q        <= ptr_inc_d;
            state_q      <= ptr_q == last_d ? IDLE : PAD;
          end
        end
        PAD: begin
          lane_data_q  <= PAD_BYTE;
          lane_we_q    <= 4'b0001 << ptr_q;
          lane_sel_q   <= ptr_q;
          pad_active_q <= 1'b1;
          group_done_q <= ptr_q == last_d;
          ptr_q        <= ptr_inc_d;
          state_q      <= ptr_q == last_d ? IDLE : PAD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
